// File: rtl/instr_encoder_loader.sv
// Instruction encoder / program loader.
// Takes instruction fields over a valid/ready stream, packs each into a
// 32-bit MIPS word and writes it to consecutive instruction-memory words.
// A legal transfer at edge N produces the write during cycle N+1; count_o
// advances when that write completes.
module instr_encoder_loader #(
   parameter int IMEM_AW = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               ins_valid_i,
   output logic               ins_ready_o,
   input  logic [3:0]         ins_class_i,
   input  logic [4:0]         rs_i,
   input  logic [4:0]         rt_i,
   input  logic [4:0]         rd_i,
   input  logic [4:0]         shamt_i,
   input  logic [15:0]        imm_i,
   input  logic               last_i,
   output logic               imem_we_o,
   output logic [IMEM_AW-1:0] imem_addr_o,
   output logic [31:0]        imem_wdata_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o,
   output logic [IMEM_AW:0]   count_o
);

   localparam int CW = IMEM_AW + 1;
   localparam logic [CW-1:0] ONE = {{IMEM_AW{1'b0}}, 1'b1};
   localparam logic [CW-1:0] CAP = {1'b1, {IMEM_AW{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Returns {legal, word}; word is meaningless when legal is 0.
   function automatic logic [32:0] encode_f(
      input logic [3:0]  cls,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [4:0]  rd,
      input logic [4:0]  sh,
      input logic [15:0] imm
   );
      logic [5:0]  code;
      logic        is_r;
      logic        legal;
      logic [32:0] res;
      code  = 6'd0;
      is_r  = 1'b1;
      legal = 1'b1;
      case (cls)
         4'd0:    code = 6'h20;
         4'd1:    code = 6'h22;
         4'd2:    code = 6'h24;
         4'd3:    code = 6'h25;
         4'd4:    code = 6'h2A;
         4'd5:    code = 6'h00;
         4'd6:    code = 6'h06;
         4'd7:    begin is_r = 1'b0; code = 6'd4;  end
         4'd8:    begin is_r = 1'b0; code = 6'd8;  end
         4'd9:    begin is_r = 1'b0; code = 6'd10; end
         4'd10:   begin is_r = 1'b0; code = 6'd15; end
         4'd11:   begin is_r = 1'b0; code = 6'd13; end
         4'd12:   begin is_r = 1'b0; code = 6'd5;  end
         default: legal = 1'b0;
      endcase
      if (is_r) begin
         // SLL takes its source from rt; only SLL carries a shift amount
         res = {legal, 6'd0, (cls == 4'd5) ? 5'd0 : rs, rt, rd,
                (cls == 4'd5) ? sh : 5'd0, code};
      end else begin
         // LUI has no source register
         res = {legal, code, (cls == 4'd10) ? 5'd0 : rs, rt, imm};
      end
      return res;
   endfunction

   state_e              state_q, state_d;
   logic [CW-1:0]       acc_q, acc_d;      // legal instructions accepted
   logic [CW-1:0]       cnt_q, cnt_d;      // writes completed
   logic                err_q, err_d;
   logic                we_q, we_d;
   logic [IMEM_AW-1:0]  addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [32:0]         enc_s;
   logic                ready_s;
   logic                xfer_s;

   assign enc_s   = encode_f(ins_class_i, rs_i, rt_i, rd_i, shamt_i, imm_i);
   assign ready_s = (state_q == S_LOAD) && (acc_q < CAP);
   assign xfer_s  = ins_valid_i && ready_s;

   // Next-state, write generation and bookkeeping.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      if (we_q) begin
         cnt_d = cnt_q + ONE;
      end else begin
         cnt_d = cnt_q;
      end
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_LOAD;
               acc_d   = {CW{1'b0}};
               cnt_d   = {CW{1'b0}};
               err_d   = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (start_i) begin
               // restart drops any transfer offered this cycle
               acc_d = {CW{1'b0}};
               cnt_d = {CW{1'b0}};
               err_d = 1'b0;
            end else if (xfer_s) begin
               if (enc_s[32]) begin
                  we_d    = 1'b1;
                  addr_d  = acc_q[IMEM_AW-1:0];
                  wdata_d = enc_s[31:0];
                  acc_d   = acc_q + ONE;
                  if (last_i) begin
                     state_d = S_DONE;
                  end else if (acc_q == (CAP - ONE)) begin
                     // memory full but program not terminated
                     state_d = S_DONE;
                     err_d   = 1'b1;
                  end else begin
                     state_d = S_LOAD;
                  end
               end else begin
                  err_d = 1'b1;
                  if (last_i) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_LOAD;
                  end
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            if (start_i) begin
               state_d = S_LOAD;
               acc_d   = {CW{1'b0}};
               cnt_d   = {CW{1'b0}};
               err_d   = 1'b0;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         acc_q   <= {CW{1'b0}};
         cnt_q   <= {CW{1'b0}};
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= {IMEM_AW{1'b0}};
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign ins_ready_o  = ready_s;
   assign imem_we_o    = we_q;
   assign imem_addr_o  = addr_q;
   assign imem_wdata_o = wdata_q;
   assign busy_o       = (state_q == S_LOAD);
   assign done_o       = (state_q == S_DONE);
   assign err_o        = err_q;
   assign count_o      = cnt_q;

endmodule
